// File: rtl/exibe_resultado_seq_pkg.sv
// Shared types and constants for the ALU result display sequencer.
// Holds state encoding, BCD sizing and flag bit positions.
package exibe_resultado_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_SHIFT = 2'b01,
    ST_SHOW  = 2'b10
  } estado_t;

  localparam int N_DIGITOS = 3;
  localparam int BCD_W     = 4;
  localparam int ACC_W     = N_DIGITOS * BCD_W;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  function automatic logic [BCD_W-1:0] digito(
    input logic [ACC_W-1:0] acc,
    input int               idx
  );
    return acc[idx*BCD_W +: BCD_W];
  endfunction

endpackage

// File: rtl/exibe_resultado_seq_add3.sv
// Combinational BCD digit corrector used by the double-dabble loop.
// Adds 3 to a digit that is 5 or more so the next shift carries right.
module bcd_ajuste_add3
  import exibe_resultado_seq_pkg::*;
(
  input  logic [BCD_W-1:0] d_i,
  output logic [BCD_W-1:0] d_o
);

  always_comb begin
    d_o = d_i;
    if (d_i >= BCD_W'(5)) begin
      d_o = d_i + BCD_W'(3);
    end
  end

endmodule

// File: rtl/exibe_resultado_seq.sv
// Captures the ALU result, converts it to three BCD digits serially
// and holds them for the display until the user acknowledges.
module exibe_resultado_seq
  import exibe_resultado_seq_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter bit SIGNED_MODE = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             capture,
  input  logic [WIDTH-1:0] result,
  input  logic [3:0]       flags_in,
  input  logic             enter,
  output logic             busy,
  output logic             valid,
  output logic             sign,
  output logic [3:0]       centena,
  output logic [3:0]       dezena,
  output logic [3:0]       unidade,
  output logic [3:0]       flags_q,
  output logic             ack
);

  localparam int CW = 4;

  estado_t          state_q;
  logic [WIDTH-1:0] bin_q;
  logic [WIDTH-1:0] bin_d;
  logic [ACC_W-1:0] bcd_q;
  logic [ACC_W-1:0] bcd_d;
  logic [ACC_W-1:0] bcd_adj;
  logic [CW-1:0]    cnt_q;

  logic             neg;
  logic [WIDTH-1:0] mag;
  logic             inicia;
  logic             fim;

  // Negating the most negative value wraps to itself, which read as
  // unsigned is exactly its magnitude.
  always_comb begin
    neg = SIGNED_MODE && result[WIDTH-1];
    mag = result;
    if (neg) begin
      mag = ~result + WIDTH'(1);
    end
  end

  for (genvar g = 0; g < N_DIGITOS; g++) begin : g_add3
    bcd_ajuste_add3 u_add3 (
      .d_i (bcd_q[g*BCD_W +: BCD_W]),
      .d_o (bcd_adj[g*BCD_W +: BCD_W])
    );
  end

  always_comb begin
    bcd_d = {bcd_adj[ACC_W-2:0], bin_q[WIDTH-1]};
    bin_d = {bin_q[WIDTH-2:0], 1'b0};
  end

  assign inicia = capture && (state_q != ST_SHIFT);
  assign fim    = (cnt_q == CW'(WIDTH));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      bin_q   <= '0;
      bcd_q   <= '0;
      cnt_q   <= '0;
      busy    <= 1'b0;
      valid   <= 1'b0;
      sign    <= 1'b0;
      centena <= '0;
      dezena  <= '0;
      unidade <= '0;
      flags_q <= '0;
      ack     <= 1'b0;
    end else begin
      ack <= (state_q == ST_SHOW) && enter;
      if (inicia) begin
        state_q <= ST_SHIFT;
        bin_q   <= mag;
        bcd_q   <= '0;
        cnt_q   <= '0;
        sign    <= neg;
        flags_q <= flags_in;
        valid   <= 1'b0;
        busy    <= 1'b0;
      end else begin
        case (state_q)
          ST_IDLE: begin
            state_q <= ST_IDLE;
          end
          ST_SHIFT: begin
            if (fim) begin
              state_q <= ST_SHOW;
              busy    <= 1'b0;
              valid   <= 1'b1;
              centena <= digito(bcd_q, 2);
              dezena  <= digito(bcd_q, 1);
              unidade <= digito(bcd_q, 0);
            end else begin
              bcd_q <= bcd_d;
              bin_q <= bin_d;
              cnt_q <= cnt_q + CW'(1);
              busy  <= 1'b1;
            end
          end
          ST_SHOW: begin
            if (enter) begin
              state_q <= ST_IDLE;
              valid   <= 1'b0;
            end
          end
          default: begin
            state_q <= ST_IDLE;
            busy    <= 1'b0;
            valid   <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: doc/exibe_resultado_seq.md
Name: exibe_resultado_seq

Overview:
Output-side sequencer for the 8-bit ALU datapath. The input controller collects A, B and the opcode. This block sits at the other end: it captures the ALU result and flags on the execute strobe and converts the result to three BCD digits with a sequential shift-add-3 algorithm. It then holds the digits for the display until the user acknowledges with enter, and returns a one-cycle acknowledge that the input controller uses to restart its FSM.

Parameters:
WIDTH, 8, result width in bits; legal range 4..8; output is always 3 BCD digits.
SIGNED_MODE, 0, 1 = interpret result as two's complement and show sign plus magnitude; 0 = unsigned.

Ports:
clk  input  1  system clock; all state changes on its rising edge.
rst  input  1  synchronous reset, active-high.
capture  input  1  execute strobe; sampled only in IDLE or SHOW.
result  input  WIDTH  ALU result, sampled in the cycle capture is accepted.
flags_in  input  4  {negative, zero, carry, overflow}, sampled with result.
enter  input  1  user acknowledge, one-cycle pulse (already debounced/edge-detected upstream).
busy  output  1  high while in SHIFT.
valid  output  1  high while in SHOW; digits are meaningful.
sign  output  1  1 = negative magnitude shown; always 0 when SIGNED_MODE=0.
centena  output  4  hundreds digit, BCD.
dezena  output  4  tens digit, BCD.
unidade  output  4  ones digit, BCD.
flags_q  output  4  flags registered at capture.
ack  output  1  one-cycle pulse when the user acknowledges in SHOW.

Behaviour:
- Reset (rst=1 at a rising edge):
  - State goes to IDLE.
  - busy, valid, sign, ack, centena, dezena, unidade and flags_q all go to 0.
  - Shift register and bit counter are cleared.
  - Reset takes priority over every other input in every state, including mid-SHIFT.
- States: IDLE, SHIFT, SHOW.
- IDLE:
  - capture=1 → load the magnitude into the shift register, clear the BCD accumulator, set counter=0, register flags_q and the sign, go to SHIFT.
  - enter is ignored.
- Magnitude and sign:
  - SIGNED_MODE=1 and result[WIDTH-1]=1 → magnitude = two's complement negation of result, sign=1.
  - The most negative value converts correctly (8-bit 0x80 → 128).
  - Otherwise magnitude = result, sign=0.
- SHIFT, one bit per cycle for exactly WIDTH cycles:
  - Each cycle, every BCD digit ≥5 gets +3, then the {BCD, binary} register shifts left by 1.
  - The counter increments each cycle; after the WIDTH-th shift, go to SHOW.
  - capture and enter are ignored.
  - centena, dezena and unidade keep their previous values throughout SHIFT.
- Latency: capture accepted at edge N → busy high after edges N+1..N+WIDTH → valid high and new digits visible after edge N+WIDTH+1. For WIDTH=8, valid rises 9 cycles after capture.
- SHOW:
  - Output digit registers are loaded on SHOW entry; valid=1.
  - enter=1 → ack=1 for exactly one cycle, valid=0, go to IDLE.
  - capture=1 → restart conversion exactly as in IDLE (valid=0, go to SHIFT).
  - capture and enter together → ack pulses and the new conversion starts (SHIFT); capture wins the state, ack is still issued.
- ack is never high outside the cycle after an accepted enter.
- Digits are held after ack and only change on the next SHOW entry or on reset.
- Arithmetic: the accumulator is 12 bits (3 digits). For WIDTH ≤ 8 the maximum magnitude is 255, so centena ≤ 2 and no digit overflow is possible.

Decomposition:
- Shared package holds:
  - state encoding constants (ST_IDLE=2'b00, ST_SHIFT=2'b01, ST_SHOW=2'b10);
  - N_DIGITOS=3 and BCD_W=4;
  - flag bit index constants (FLAG_N, FLAG_Z, FLAG_C, FLAG_V).
- One sub-module: bcd_ajuste_add3, a combinational 4-bit "if ≥5 then +3" corrector, instantiated once per digit.

Test Plan:
1. Unsigned max: SIGNED_MODE=0, result=8'hFF, flags=4'b0010, capture pulse → busy for 8 cycles; valid after 9; digits 2,5,5; sign=0; flags_q=4'b0010.
2. Signed most-negative: SIGNED_MODE=1, result=8'h80 → sign=1, digits 1,2,8. Then result=8'hF6 → sign=1, digits 0,1,0.
3. Zero and ignore-while-busy: result=0, capture → digits 0,0,0. A second capture with result=8'h63 on SHIFT cycle 3 is ignored, and the outcome is still 0,0,0 at the same cycle.
4. Acknowledge: in SHOW, enter pulse → ack high for exactly one cycle, valid=0, state IDLE, digits held. A further enter in IDLE produces no ack.
5. Simultaneous events: in SHOW, capture and enter in the same cycle with result=8'd42 → one ack pulse, busy next cycle, digits 0,4,2 after 9 cycles.
6. Reset mid-operation: rst on SHIFT cycle 4 → next cycle all outputs 0, state IDLE. A fresh capture of 8'd99 then yields 0,9,9 with the normal latency.
